// File: rtl/program_loader_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : program_loader_pkg                                              |
// | Brief    : Shared types and constants for the program loader               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

    localparam logic [7:0] c_HEADER = 8'hA5;

    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_loader_byte_assembler.sv
// +----------------------------------------------------------------------------+
// | Module   : program_loader_byte_assembler                                   |
// | Brief    : Shifts in MSB-first bytes and presents a WIDTH-bit word         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module program_loader_byte_assembler
    import program_loader_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic [WIDTH-1:0] word,
    output logic             word_complete
);

    localparam int BPW   = bytes_per_word(WIDTH);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BPW - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (byte_valid) begin
            count_d = (count_q == c_LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign word_complete = byte_valid && !clear && (count_q == c_LAST);

    generate
        if (WIDTH > 8) begin : g_wide
            logic [WIDTH-1:0] shift_q, shift_d;
            // Older bytes fall off the top, so pad bits of the first byte vanish on their own.
            logic [7:0]       w_unused_top;

            always_comb begin
                shift_d = shift_q;
                if (clear) begin
                    shift_d = '0;
                end else if (byte_valid) begin
                    shift_d = {shift_q[WIDTH-9:0], byte_data};
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    shift_q <= '0;
                end else begin
                    shift_q <= shift_d;
                end
            end

            assign word         = shift_d;
            assign w_unused_top = shift_q[WIDTH-1:WIDTH-8];
        end else begin : g_narrow
            logic [7:0] w_unused_byte;
            assign word          = byte_data[WIDTH-1:0];
            assign w_unused_byte = byte_data;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// +----------------------------------------------------------------------------+
// | Module   : program_loader                                                  |
// | Brief    : Framed byte-stream writer for CPU program memory; holds the CPU |
// |            in reset until an image loads cleanly. Checksum byte enabled by |
// |            defining PROGRAM_LOADER_CHECKSUM_EN.                            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module program_loader
    import program_loader_pkg::*;
#(
    parameter int         WIDTH         = 16,
    parameter int         COUNTER_WIDTH = 4,
    parameter logic [7:0] HEADER        = c_HEADER
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [COUNTER_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     error
);

    localparam logic [31:0] c_DEPTH = 32'(2 ** COUNTER_WIDTH);

    loader_state_t            state_q, state_d;
    logic [COUNTER_WIDTH-1:0] addr_q, addr_d;
    logic [COUNTER_WIDTH-1:0] last_q, last_d;
    logic                     mem_we_q, mem_we_d;
    logic [COUNTER_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]         mem_wdata_q, mem_wdata_d;
    logic                     cpu_hold_q, cpu_hold_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]               csum_q, csum_d;
`endif

    logic             w_take;
    logic             w_is_header;
    logic [31:0]      w_len_ext;
    logic             w_len_bad;
    logic             w_asm_valid;
    logic             w_asm_clear;
    logic             w_word_complete;
    logic [WIDTH-1:0] w_word;

    assign in_ready    = !mem_we_q;
    assign w_take      = in_valid && in_ready;
    assign w_is_header = (in_data == HEADER);
    assign w_len_ext   = {24'd0, in_data};
    assign w_len_bad   = (w_len_ext == 32'd0) || (w_len_ext > c_DEPTH);
    assign w_asm_valid = w_take && (state_q == ST_DATA);
    assign w_asm_clear = (state_q != ST_DATA);

    program_loader_byte_assembler #(
        .WIDTH(WIDTH)
    ) u_assembler (
        .clock        (clock),
        .reset        (reset),
        .clear        (w_asm_clear),
        .byte_valid   (w_asm_valid),
        .byte_data    (in_data),
        .word         (w_word),
        .word_complete(w_word_complete)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (w_take && w_is_header) begin
                    state_d = ST_LEN;
                end
            end

            ST_LEN: begin
                if (w_take) begin
                    if (w_len_bad) begin
                        state_d    = ST_ERROR;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                        addr_d  = '0;
                        last_d  = COUNTER_WIDTH'(w_len_ext - 32'd1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum_d  = 8'd0;
`endif
                    end
                end
            end

            ST_DATA: begin
                if (mem_we_q) begin
                    // The address only advances between words, so it saturates at the last one.
                    if (addr_q == last_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d    = ST_CSUM;
`else
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
`endif
                    end else begin
                        addr_d = addr_q + COUNTER_WIDTH'(1);
                    end
                end else if (w_take) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    if (w_word_complete) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = w_word;
                    end
                end
            end

            ST_CSUM: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (w_take) begin
                    if (in_data == csum_q) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = ST_ERROR;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end

            ST_DONE, ST_ERROR: begin
                if (w_take && w_is_header) begin
                    state_d    = ST_LEN;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_program_loader                                               |
// | Brief    : Scoreboard bench for program_loader (WIDTH=16, COUNTER_WIDTH=4) |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_program_loader;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          n_total = 0;
    int          n_bad   = 0;
    exp_wr_t     sb_q[$];
    logic [15:0] model_mem [16];
    logic [7:0]  tx[$];

    always #5 clock = ~clock;

    program_loader #(
        .WIDTH        (16),
        .COUNTER_WIDTH(4),
        .HEADER       (8'hA5)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: stall rule every cycle, scoreboard on every write strobe.
    always @(negedge clock) begin
        if (!reset) begin
            check_eq("in_ready_vs_we", 32'(in_ready), 32'(!mem_we));
            if (mem_we) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_we_addr", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    exp_wr_t e;
                    e = sb_q.pop_front();
                    check_eq("we_addr", 32'(mem_addr), 32'(e.addr));
                    check_eq("we_data", 32'(mem_wdata), 32'(e.data));
                end
                model_mem[mem_addr] = mem_wdata;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit accepted = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 8 && !accepted; i++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                accepted = 1;
            end
        end
        if (!accepted) check_eq("accept_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send_tx();
        for (int i = 0; i < tx.size(); i++) send_byte(tx[i]);
        in_valid = 1'b0;
    endtask

    // Without a checksum byte, done rises one cycle after the final write strobe.
    task automatic settle_done();
`ifndef PROGRAM_LOADER_CHECKSUM_EN
        @(posedge clock);
        #1;
`endif
    endtask

    task automatic check_status(input string tag, input logic e_done, input logic e_err, input logic e_hold);
        check_eq({tag, "_done"},  32'(done),     32'(e_done));
        check_eq({tag, "_error"}, 32'(error),    32'(e_err));
        check_eq({tag, "_hold"},  32'(cpu_hold), 32'(e_hold));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check_eq({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check_eq({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check_status(tag, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0]  csum;
        logic [15:0] w;

        for (int i = 0; i < 16; i++) model_mem[i] = 16'h0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;

        // Good load of two words
        sb_q.push_back('{addr: 4'd0, data: 16'h1234});
        sb_q.push_back('{addr: 4'd1, data: 16'h5678});
        tx = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        tx.push_back(8'h08);
`endif
        send_tx();
        settle_done();
        check_status("good", 1'b1, 1'b0, 1'b0);
        check_eq("good_mem0", 32'(model_mem[0]), 32'h1234);
        check_eq("good_mem1", 32'(model_mem[1]), 32'h5678);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Bad checksum: word still lands, frame rejected
        sb_q.push_back('{addr: 4'd0, data: 16'hABCD});
        tx = '{8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h00};
        send_tx();
        check_status("badcsum", 1'b0, 1'b1, 1'b1);
        check_eq("badcsum_mem0", 32'(model_mem[0]), 32'hABCD);
`endif

        // Zero length
        tx = '{8'hA5, 8'h00};
        send_tx();
        check_status("len0", 1'b0, 1'b1, 1'b1);

        // Length 17 exceeds depth; monitor flags any write
        tx = '{8'hA5, 8'h11};
        send_tx();
        check_status("len17", 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clock);
        #1;
        check_eq("len17_no_we", 32'(mem_we), 32'd0);

        // Full-depth load, all 16 addresses, no wrap
        tx = '{8'hA5, 8'h10};
        csum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            w = {4'(i), 4'(15 - i), 8'h3C ^ 8'(i * 7)};
            sb_q.push_back('{addr: 4'(i), data: w});
            tx.push_back(w[15:8]);
            tx.push_back(w[7:0]);
            csum = csum ^ w[15:8] ^ w[7:0];
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        tx.push_back(csum);
`endif
        send_tx();
        settle_done();
        check_status("full", 1'b1, 1'b0, 1'b0);
        check_eq("full_last_addr", 32'(mem_addr), 32'hF);
        check_eq("full_sb_drained", 32'(sb_q.size()), 32'd0);
        check_eq("full_mem15", 32'(model_mem[15]), 32'({4'd15, 4'd0, 8'h3C ^ 8'd105}));

        // Garbage before header, then restart clears done
        sb_q.push_back('{addr: 4'd0, data: 16'h0001});
        tx = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h01};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        tx.push_back(8'h01);
`endif
        send_tx();
        settle_done();
        check_status("garbage", 1'b1, 1'b0, 1'b0);
        tx = '{8'hA5};
        send_tx();
        check_status("restart", 1'b0, 1'b0, 1'b1);

        // Reset after three data bytes
        sb_q.push_back('{addr: 4'd0, data: 16'h1122});
        tx = '{8'h02, 8'h11, 8'h22, 8'h33};
        send_tx();
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_vals("midreset");
        reset = 1'b0;
        check_eq("midreset_sb_drained", 32'(sb_q.size()), 32'd0);

        // Loader back in IDLE: a fresh one-word load works
        sb_q.push_back('{addr: 4'd0, data: 16'h1234});
        tx = '{8'hA5, 8'h01, 8'h12, 8'h34};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        tx.push_back(8'h26);
`endif
        send_tx();
        settle_done();
        check_status("after_reset", 1'b1, 1'b0, 1'b0);
        check_eq("after_reset_mem0", 32'(model_mem[0]), 32'h1234);
        check_eq("final_sb_drained", 32'(sb_q.size()), 32'd0);

        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
